// File: rtl/midi_tx.sv
// MIDI 1.0 transmitter: takes one packed (status, data1, data2) message and sends 8N1, LSB first.
// Optional feature macro MIDI_TX_RUNNING_STATUS_EN drops a repeated channel status byte (running status).
module midi_tx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 31_250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] in_bytes,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        serial,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [1:0]       byte_idx, byte_idx_d;
    logic [1:0]       byte_last, byte_last_d;
    logic [23:0]      msg, msg_d;
    logic [7:0]       cur_byte;
    logic             serial_d, done_d, err_d;
    logic             accept, bit_end;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic [7:0]       last_status, last_status_d;
`endif

    // Index of the final byte to send, from the MIDI message length of the status byte.
    function automatic logic [1:0] final_index(input logic [7:0] status);
        logic [1:0] idx;
        idx = 2'd2;
        case (status[7:4])
            4'hC, 4'hD: idx = 2'd1;
            4'hF: begin
                case (status[3:0])
                    4'h2:       idx = 2'd2;
                    4'h1, 4'h3: idx = 2'd1;
                    default:    idx = 2'd0;
                endcase
            end
            default: idx = 2'd2;
        endcase
        return idx;
    endfunction

    function automatic logic [7:0] pick_byte(input logic [23:0] m, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = m[23:16];
            2'd1:    b = m[15:8];
            default: b = m[7:0];
        endcase
        return b;
    endfunction

    assign accept  = in_valid && (state == IDLE);
    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        bit_idx_d   = bit_idx;
        byte_idx_d  = byte_idx;
        byte_last_d = byte_last;
        msg_d       = msg;
`ifdef MIDI_TX_RUNNING_STATUS_EN
        last_status_d = last_status;
`endif
        case (state)
            IDLE: begin
                if (accept && in_bytes[23]) begin
                    msg_d       = in_bytes;
                    state_d     = START;
                    cnt_d       = '0;
                    bit_idx_d   = '0;
                    byte_idx_d  = 2'd0;
                    byte_last_d = final_index(in_bytes[23:16]);
`ifdef MIDI_TX_RUNNING_STATUS_EN
                    // Channel messages (80-EF) may reuse the status; system common clears it, realtime keeps it.
                    if (in_bytes[23:20] != 4'hF) begin
                        if (in_bytes[23:16] == last_status) begin
                            byte_idx_d = 2'd1;
                        end
                        last_status_d = in_bytes[23:16];
                    end else if (!in_bytes[19]) begin
                        last_status_d = '0;
                    end
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (byte_idx == byte_last) begin
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx + 2'd1;
                        state_d    = START;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Serial is registered from the next-state view so the line never glitches.
    always_comb begin
        cur_byte = pick_byte(msg_d, byte_idx_d);
        in_ready = (state == IDLE);
        busy     = (state != IDLE) || (accept && in_bytes[23]);
        done_d   = (state == STOP) && bit_end && (byte_idx == byte_last);
        err_d    = accept && !in_bytes[23];
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = cur_byte[bit_idx_d];
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            byte_last <= '0;
            msg       <= '0;
            serial    <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
            last_status <= '0;
`endif
        end else begin
            cnt       <= cnt_d;
            bit_idx   <= bit_idx_d;
            byte_idx  <= byte_idx_d;
            byte_last <= byte_last_d;
            msg       <= msg_d;
            serial    <= serial_d;
            done      <= done_d;
            err       <= err_d;
`ifdef MIDI_TX_RUNNING_STATUS_EN
            last_status <= last_status_d;
`endif
        end
    end

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: a queue-based line model checked every cycle, plus directed latency/frame literals.
// Runs with a reduced clock so that one bit lasts 16 cycles.
module tb_midi_tx;

    localparam int CLK_HZ = 500_000;
    localparam int BAUD   = 31_250;
    localparam int CPB    = 16;
    localparam int FRAME  = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_bytes = '0;
    logic        in_ready, serial, busy, done, err;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int acc_cycle = 0;

    bit         model_q[$];
    bit         done_pend = 1'b0;
    bit         err_pend = 1'b0;
    logic [7:0] rs_last = '0;
    bit         exp_ser, exp_ready, exp_busy, exp_done, exp_err;
    logic [9:0] frame;

    midi_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_bytes (in_bytes),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .serial   (serial),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, wanted %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Expected line waveform for an accepted message, one queue entry per clock cycle.
    task automatic model_accept(input logic [23:0] m);
        logic [7:0] s, b;
        int n, first;
        s = m[23:16];
        if (!s[7]) begin
            err_pend = 1'b1;
            return;
        end
        if (s >= 8'hF0) n = (s == 8'hF2) ? 3 : ((s == 8'hF1 || s == 8'hF3) ? 2 : 1);
        else if (s >= 8'hC0 && s < 8'hE0) n = 2;
        else n = 3;
        first = 0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
        if (s < 8'hF0 && s == rs_last) first = 1;
        if (s < 8'hF0) rs_last = s;
        else if (s < 8'hF8) rs_last = '0;
`endif
        for (int k = first; k < n; k++) begin
            b = m[23 - 8 * k -: 8];
            repeat (CPB) model_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (CPB) model_q.push_back(b[i]);
            repeat (CPB) model_q.push_back(1'b1);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            model_q.delete();
            done_pend = 1'b0;
            err_pend  = 1'b0;
            rs_last   = '0;
            check_output("rst_serial", serial, 1);
            check_output("rst_ready", in_ready, 1);
            check_output("rst_busy", busy, 0);
            check_output("rst_done", done, 0);
            check_output("rst_err", err, 0);
        end else begin
            exp_ready = (model_q.size() == 0);
            exp_busy  = !exp_ready || (in_valid && in_bytes[23]);
            exp_done  = done_pend;
            exp_err   = err_pend;
            err_pend  = 1'b0;
            if (model_q.size() > 0) begin
                exp_ser   = model_q.pop_front();
                done_pend = (model_q.size() == 0);
            end else begin
                exp_ser   = 1'b1;
                done_pend = 1'b0;
            end
            check_output("serial", serial, exp_ser);
            check_output("in_ready", in_ready, exp_ready);
            check_output("busy", busy, exp_busy);
            check_output("done", done, exp_done);
            check_output("err", err, exp_err);
            if (in_valid && exp_ready) model_accept(in_bytes);
        end
    end

    task automatic apply_stimulus(input logic [23:0] m);
        int t;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_bytes = m;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 5000);
        check_output("accept", in_ready, 1);
        acc_cycle = cycle;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bytes = 24'($urandom());
    endtask

    task automatic wait_done(input int lat, input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (done !== 1'b1 && t < 5000);
        check_output(name, cycle - acc_cycle, lat);
    endtask

    // Samples the middle of each of the ten bits of the first frame: {stop, data, start}.
    task automatic sample_frame(output logic [9:0] bits);
        repeat (CPB / 2) @(negedge clk);
        bits[0] = serial;
        for (int i = 1; i < 10; i++) begin
            repeat (CPB) @(negedge clk);
            bits[i] = serial;
        end
    endtask

    task automatic apply_b2b(input logic [23:0] a, input logic [23:0] b);
        int t1, t;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_bytes = a;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 5000);
        t1 = cycle;
        @(posedge clk);
        #1;
        in_bytes = b;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 5000);
        check_output("b2b_second_accept", cycle - t1, 1 + 3 * FRAME);
        check_output("b2b_done_same_cycle", done, 1);
        acc_cycle = cycle;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_output("b2b_next_start", serial, 0);
        wait_done(1 + 3 * FRAME, "b2b_latency");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        apply_stimulus(24'h90_3C_64);
        sample_frame(frame);
        check_output("frame_0x90", 32'(frame), 32'h320);
        wait_done(481, "lat_90_3byte");

        apply_stimulus(24'hC0_05_77);
        wait_done(321, "lat_C0_2byte");
        apply_stimulus(24'hF8_12_34);
        wait_done(161, "lat_F8_1byte");

        apply_b2b(24'hB0_07_40, 24'hE0_00_40);

        apply_stimulus(24'h3C_40_00);
        @(negedge clk);
        check_output("err_pulse", err, 1);
        check_output("err_line_idle", serial, 1);
        apply_stimulus(24'h80_3C_00);
        wait_done(481, "lat_after_err");

        apply_stimulus(24'h90_3C_64);
        repeat (FRAME + 3 * CPB + CPB / 2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_serial", serial, 1);
        check_output("async_rst_busy", busy, 0);
        check_output("async_rst_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(24'h80_3C_00);
        sample_frame(frame);
        check_output("frame_0x80", 32'(frame), 32'h300);
        wait_done(481, "lat_after_reset");

`ifdef MIDI_TX_RUNNING_STATUS_EN
        apply_stimulus(24'h90_3C_64);
        wait_done(481, "rs_first_full");
        apply_stimulus(24'h90_40_64);
        sample_frame(frame);
        check_output("rs_frame_0x40", 32'(frame), 32'h280);
        wait_done(321, "rs_omitted");
        apply_stimulus(24'hF8_00_00);
        wait_done(161, "rs_realtime");
        apply_stimulus(24'h90_43_64);
        wait_done(321, "rs_kept_after_rt");
        apply_stimulus(24'hF2_01_02);
        wait_done(481, "rs_song_pos");
        apply_stimulus(24'h90_45_64);
        wait_done(481, "rs_resent");
`endif

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
